stage_pipe_ctrl: RTL

Valid/ready sequencer for the packet-header field register chain. It tracks occupancy of a NUM_STAGES-deep elastic pipeline of field registers and drives one load enable per stage. It propagates downstream backpressure back to the parser and supports graceful drain and immediate abort. It sits beside the stageN field register banks, and each bank's d-to-q transfer is gated by the matching stage_en bit.

---
 rtl/stage_pipe_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stage_pipe_ctrl.sv
// stage_pipe_ctrl: valid/ready sequencer for the packet-header field register
// chain. Tracks occupancy of a NUM_STAGES-deep elastic pipeline, drives one load
// enable per stage (bubbles collapse), propagates downstream backpressure to the
// parser, and supports graceful drain (flush) and immediate discard (abort).
// Optional statistics counters are built only when STAGE_PIPE_STATS_EN is
// defined; otherwise pkt_cnt/drop_cnt are tied to zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_valid may not depend on in_ready. in_ready depends combinationally on
// out_ready, flush and abort. out_valid is a pure register output.
module stage_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  busy,
  output logic                  drain_done,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] en_w;
  logic                  drain_done_q;
  logic                  accept;

  // Load-enable chain: a stage may load if it is empty or its successor loads.
  always_comb begin
    logic carry;
    en_w  = '0;
    carry = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      carry   = ~valid_q[i] | carry;
      en_w[i] = carry;
    end
  end

  // Flush also blocks acceptance in its own cycle so nothing new enters a drain.
  assign in_ready = en_w[0] & ((state_q == ST_IDLE) | (state_q == ST_RUN)) & ~abort & ~flush;
  assign accept   = in_valid & in_ready;

  // Next occupancy: enabled stages take their predecessor's valid bit.
  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = en_w[0] ? accept : valid_q[0];
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (en_w[i]) valid_d[i] = valid_q[i-1];
    end
  end

  // Control FSM with occupancy and the registered drain_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      if (abort) begin
        valid_q <= '0;
        state_q <= ST_IDLE;
      end else begin
        valid_q <= valid_d;
        case (state_q)
          ST_DRAIN: begin
            // flush is ignored here; only emptiness ends the drain
            if (valid_d == '0) begin
              drain_done_q <= 1'b1;
              state_q      <= ST_IDLE;
            end
          end
          default: begin
            if (flush) begin
              if (valid_d == '0) begin
                drain_done_q <= 1'b1;
                state_q      <= ST_IDLE;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else if (valid_d == '0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        endcase
      end
    end
  end

  assign stage_en    = en_w;
  assign stage_valid = valid_q;
  assign out_valid   = valid_q[NUM_STAGES-1];
  assign busy        = (|valid_q) | (state_q != ST_IDLE);
  assign drain_done  = drain_done_q;
  assign dbg_state   = state_q;

`ifdef STAGE_PIPE_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [CNT_WIDTH:0]   WIDE_ONE = 1;

  logic                 xfer;
  logic [CNT_WIDTH-1:0] pkt_q;
  logic [CNT_WIDTH-1:0] drop_q;
  logic [CNT_WIDTH:0]   drop_n;
  logic [CNT_WIDTH:0]   drop_sum;

  assign xfer = valid_q[NUM_STAGES-1] & out_ready;

  // Entries lost to an abort: every occupied stage except one leaving via output.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (valid_q[i]) drop_n = drop_n + WIDE_ONE;
    end
    if (xfer) drop_n = drop_n - WIDE_ONE;
    drop_sum = {1'b0, drop_q} + drop_n;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (xfer && (pkt_q != '1)) pkt_q <= pkt_q + CNT_ONE;
      if (abort) drop_q <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
`else
  assign pkt_cnt  = {CNT_WIDTH{1'b0}};
  assign drop_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule
